// File: rtl/seg_scan.sv
// seg_scan: 8-digit seven-segment scan controller with double-buffered display data.
// Latency: num/seg/frame_done registered, updated together on the tick edge; loads show from next frame.
// Backpressure: none; load is a one-cycle strobe that is always accepted (last load in a frame wins).
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.

module seg_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [2:0]  num,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          wrap;
  logic [2:0]    num_nxt;

  logic [31:0]   pend_val;
  logic [7:0]    pend_dp;
  logic [31:0]   act_val;
  logic [7:0]    act_dp;
  logic [31:0]   act_val_nxt;
  logic [7:0]    act_dp_nxt;

  logic [3:0]    nib;
  logic [7:0]    seg_nxt;

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] p;
    case (h)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  assign tick    = (pcnt == PMAX);
  assign wrap    = tick && (num == 3'd7);
  assign num_nxt = num + 3'd1;

  // Active buffer as it will be after this edge; a load on the boundary bypasses pending.
  always_comb begin
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    if (wrap) begin
      act_val_nxt = load ? value : pend_val;
      act_dp_nxt  = load ? dp_in : pend_dp;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [7:0] keep;

  // A digit is kept if it or any higher digit has a non-zero nibble or a lit dp; digit 0 always kept.
  always_comb begin
    keep    = '0;
    keep[7] = (act_val_nxt[31:28] != 4'h0) || act_dp_nxt[7];
    for (int i = 6; i >= 0; i--) begin
      keep[i] = keep[i+1] || (act_val_nxt[i*4 +: 4] != 4'h0) || act_dp_nxt[i];
    end
    keep[0] = 1'b1;
  end
`endif

  // Segment pattern for the digit that becomes current on the next tick.
  always_comb begin
    nib     = act_val_nxt[{num_nxt, 2'b00} +: 4];
    seg_nxt = {~act_dp_nxt[num_nxt], hex7(nib)};
    if (!digit_en[num_nxt]) begin
      seg_nxt = 8'hFF;
    end
`ifdef SEG_SCAN_LZB_EN
    if (!keep[num_nxt]) begin
      seg_nxt = 8'hFF;
    end
`endif
  end

  // Prescaler: one tick every CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Pending buffer takes every load; active buffer refreshes only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      act_val  <= '0;
      act_dp   <= '0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
    end
  end

  // Digit index, segments and frame pulse all move on the same rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num        <= 3'd0;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        num <= num_nxt;
        seg <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with CLK_DIV=4: scoreboard of expected per-digit segments, checked as digits appear.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// Honours SEG_SCAN_LZB_EN in its expectation model.

module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [2:0]  num;
  logic [7:0]  seg;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sbq[$];

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .num        (num),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] dp,
                                         input logic [7:0] en, input int idx);
    logic [7:0] r;
`ifdef SEG_SCAN_LZB_EN
    int msd;
`endif
    if (!en[idx]) return 8'hFF;
`ifdef SEG_SCAN_LZB_EN
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] != 4'h0 || dp[i]) msd = i;
    end
    if (idx > msd) return 8'hFF;
`endif
    r    = HEX[v[idx*4 +: 4]];
    r[7] = ~dp[idx];
    return r;
  endfunction

  task automatic push_digits(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en,
                             input int first, input int last);
    for (int d = first; d <= last; d++) sbq.push_back(exp_seg(v, dp, en, d));
  endtask

  // Step to the next negedge where frame_done is high; returns cycles taken.
  task automatic sync_wrap(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      cyc++;
    end while (!frame_done && cyc < 100);
    if (!frame_done) begin
      n_cmp++; n_err++;
      $display("FAIL wrap_timeout: no frame_done within %0d cycles", cyc);
    end
  endtask

  task automatic wait_num(input logic [2:0] t);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (num !== t && c < 100);
    if (num !== t) begin
      n_cmp++; n_err++;
      $display("FAIL num_timeout: num=%0d expected %0d", num, t);
    end
  endtask

  // Starting at the first negedge of digit 'first', check each digit against the scoreboard.
  task automatic check_digits(input string name, input int first, input int last);
    logic [7:0] e;
    int cnt;
    for (int d = first; d <= last; d++) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL %s_sb_empty: digit %0d has no expectation", name, d);
        e = 8'hxx;
      end else begin
        e = sbq.pop_front();
        if (seg !== e) begin
          n_err++;
          $display("FAIL %s_seg%0d: seg=%h expected %h", name, d, seg, e);
        end
      end
      n_cmp++;
      if (num !== 3'(d)) begin
        n_err++;
        $display("FAIL %s_num: num=%0d expected %0d", name, num, d);
      end
      n_cmp++;
      if (frame_done !== (d == 0)) begin
        n_err++;
        $display("FAIL %s_fd%0d: frame_done=%b expected %b", name, d, frame_done, (d == 0));
      end
      cnt = 0;
      do begin
        @(negedge clk);
        load = 1'b0;
        cnt++;
      end while (num === 3'(d) && cnt < 20);
      n_cmp++;
      if (cnt != 4) begin
        n_err++;
        $display("FAIL %s_dwell%0d: held %0d cycles expected 4", name, d, cnt);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = 8'hFF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (num !== 3'd0 || seg !== 8'hFF || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: num=%0d seg=%h fd=%b expected 0 ff 0", num, seg, frame_done);
    end
    rst_n = 1'b1;
    wait_num(3'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (num !== 3'd0 || seg !== 8'hFF || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: num=%0d seg=%h fd=%b expected 0 ff 0", num, seg, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (num !== 3'd0) begin
      n_err++;
      $display("FAIL release_early: num=%0d expected 0 after 3 cycles", num);
    end
    @(negedge clk);
    n_cmp++;
    if (num !== 3'd1) begin
      n_err++;
      $display("FAIL release_tick: num=%0d expected 1 after 4 cycles", num);
    end
  endtask

  task automatic test_reset_frame();
    int c;
    push_digits(32'h0, 8'h00, 8'hFF, 0, 7);
    sync_wrap(c);
    check_digits("rstframe", 0, 7);
  endtask

  task automatic test_load();
    int c;
    load = 1'b1; value = 32'h12345678; dp_in = 8'h00;
    @(negedge clk);
    load = 1'b0;
    push_digits(32'h12345678, 8'h00, 8'hFF, 0, 7);
    sync_wrap(c);
    check_digits("load", 0, 7);
    sync_wrap(c);
    n_cmp++;
    if (c != 32) begin
      n_err++;
      $display("FAIL frame_period: %0d cycles expected 32", c);
    end
  endtask

  task automatic test_mid_frame();
    push_digits(32'h12345678, 8'h00, 8'hFF, 3, 7);
    wait_num(3'd3);
    load = 1'b1; value = 32'hFFFFFFFF;
    check_digits("midold", 3, 7);
    push_digits(32'hFFFFFFFF, 8'h00, 8'hFF, 0, 7);
    check_digits("midnew", 0, 7);
  endtask

  task automatic test_same_cycle();
    push_digits(32'hA5C3E1F0, 8'h00, 8'hFF, 0, 7);
    wait_num(3'd7);
    repeat (3) @(negedge clk);
    load = 1'b1; value = 32'hA5C3E1F0;
    @(negedge clk);
    load = 1'b0;
    check_digits("same", 0, 7);
  endtask

  task automatic test_blank_dp();
    int c;
    load = 1'b1; value = 32'h12345678; dp_in = 8'h08; digit_en = 8'h0F;
    @(negedge clk);
    load = 1'b0;
    push_digits(32'h12345678, 8'h08, 8'h0F, 0, 7);
    sync_wrap(c);
    check_digits("blank", 0, 7);
    digit_en = 8'hFF; dp_in = 8'h00;
  endtask

  task automatic test_lzb();
    int c;
    load = 1'b1; value = 32'h00000012; dp_in = 8'h00;
    @(negedge clk);
    load = 1'b0;
    push_digits(32'h00000012, 8'h00, 8'hFF, 0, 7);
    sync_wrap(c);
    check_digits("lzb", 0, 7);
    load = 1'b1; value = 32'h00000012; dp_in = 8'h20;
    @(negedge clk);
    load = 1'b0;
    push_digits(32'h00000012, 8'h20, 8'hFF, 0, 7);
    sync_wrap(c);
    check_digits("lzbdp", 0, 7);
  endtask

  initial begin
    test_reset();
    test_reset_frame();
    test_load();
    test_mid_frame();
    test_same_cycle();
    test_blank_dp();
    test_lzb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
